// File: rtl/adc_sample_decimator.sv
// adc_sample_decimator
// Pops raw words from the read side of the ADC sample FIFO, extracts the
// MSB-aligned signed ADC code, averages 2^DECIM_LOG2 consecutive codes and
// presents each block average on a valid/ready interface. Full-scale codes
// are flagged per block, and accepted averages are counted.
//
// Output handshake: avg_valid rises once a block is complete and stays high,
// with avg_data/avg_clip stable, until a rising clock edge sees avg_valid and
// avg_ready both high. That edge is the transfer; avg_valid drops after it.
module adc_sample_decimator #(
  parameter int DATA_W     = 32,
  parameter int SAMPLE_W   = 24,
  parameter int DECIM_LOG2 = 3
) (
  input  logic                system_clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [DATA_W-1:0]   fifo_q,
  input  logic                fifo_rdempty,
  output logic                fifo_rdreq,
  output logic [SAMPLE_W-1:0] avg_data,
  output logic                avg_valid,
  input  logic                avg_ready,
  output logic                avg_clip,
  output logic [15:0]         block_count,
  output logic [1:0]          dbg_state
);

  localparam int ACC_W = SAMPLE_W + DECIM_LOG2;
  localparam int CNT_W = DECIM_LOG2 + 1;
  localparam int NSAMP = 1 << DECIM_LOG2;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NSAMP);

  localparam logic [SAMPLE_W-1:0] CODE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] CODE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;
  localparam logic [1:0] S_EMIT = 2'd3;

  logic [1:0]                state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      clip_q, clip_d;
  logic [SAMPLE_W-1:0]       avg_data_q, avg_data_d;
  logic                      avg_clip_q, avg_clip_d;
  logic [15:0]               count_q, count_d;

  // Code extraction and per-sample arithmetic used in CAP.
  logic [SAMPLE_W-1:0]       code;
  logic signed [ACC_W-1:0]   code_ext;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W-1:0]   acc_shift;
  logic [CNT_W-1:0]          cnt_inc;
  logic                      clip_now;
  logic                      unused_low_bits;

  assign code      = fifo_q[DATA_W-1 -: SAMPLE_W];
  assign code_ext  = ACC_W'($signed(code));
  assign acc_sum   = acc_q + code_ext;
  // Arithmetic shift floors toward -inf; the sum always fits ACC_W bits.
  assign acc_shift = acc_sum >>> DECIM_LOG2;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign clip_now  = (code == CODE_MAX) || (code == CODE_MIN);
  // Low bits carry status/CRC padding and are intentionally ignored.
  assign unused_low_bits = ^fifo_q[DATA_W-SAMPLE_W-1:0];

  // Next-state logic: read sequencing, accumulation and output handshake.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    clip_d     = clip_q;
    avg_data_d = avg_data_q;
    avg_clip_d = avg_clip_q;
    count_d    = count_q;
    case (state_q)
      S_IDLE: begin
        if (enable && !fifo_rdempty) state_d = S_REQ;
      end
      S_REQ: begin
        // fifo_q is valid on the edge that leaves CAP.
        state_d = S_CAP;
      end
      S_CAP: begin
        if (cnt_inc == CNT_FULL) begin
          avg_data_d = acc_shift[SAMPLE_W-1:0];
          avg_clip_d = clip_q | clip_now;
          acc_d      = '0;
          cnt_d      = '0;
          clip_d     = 1'b0;
          state_d    = S_EMIT;
        end else begin
          acc_d   = acc_sum;
          cnt_d   = cnt_inc;
          clip_d  = clip_q | clip_now;
          state_d = S_IDLE;
        end
      end
      S_EMIT: begin
        if (avg_ready) begin
          count_d = count_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers, cleared asynchronously so a reset discards any block.
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      clip_q     <= 1'b0;
      avg_data_q <= '0;
      avg_clip_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      clip_q     <= clip_d;
      avg_data_q <= avg_data_d;
      avg_clip_q <= avg_clip_d;
      count_q    <= count_d;
    end
  end

  assign fifo_rdreq  = (state_q == S_REQ);
  assign avg_valid   = (state_q == S_EMIT);
  assign avg_data    = avg_data_q;
  assign avg_clip    = avg_clip_q;
  assign block_count = count_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/adc_sample_decimator.md
Name: adc_sample_decimator

Overview:
- Sits directly downstream of the ADC acquisition wrapper's dual-clock sample FIFO, on that FIFO's read-clock side.
- Pops 32-bit raw channel-0 words and extracts the 24-bit signed two's-complement ADC code.
- Averages 2^DECIM_LOG2 consecutive codes and presents each block average on a valid/ready interface to the host/telemetry logic.
- Flags full-scale (clipped) codes and counts emitted averages.

Parameters:
- DATA_W, 32: FIFO word width.
- SAMPLE_W, 24: ADC code width; the code is word bits [DATA_W-1 : DATA_W-SAMPLE_W] (MSB-aligned).
- DECIM_LOG2, 3: log2 of samples per average (default 8); legal range 0..8.

Ports:
- system_clock, in, 1: FIFO read-side clock; all logic on rising edge.
- reset, in, 1: asynchronous, active-high reset.
- enable, in, 1: when low, no new FIFO reads are issued.
- fifo_q, in, DATA_W: FIFO read data, valid the cycle after fifo_rdreq (normal-mode FIFO).
- fifo_rdempty, in, 1: FIFO empty.
- fifo_rdreq, out, 1: FIFO read request, single-cycle pulse.
- avg_data, out, SAMPLE_W: signed block average.
- avg_valid, out, 1: avg_data/avg_clip valid.
- avg_ready, in, 1: consumer accepts when avg_valid and avg_ready are both high on a clock edge.
- avg_clip, out, 1: at least one code in this block was 0x7FFFFF or 0x800000.
- block_count, out, 16: number of averages accepted by the consumer; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (asynchronous, any state): all outputs are 0; state = IDLE; accumulator, sample counter and clip-accumulator are cleared.
- States: IDLE, REQ, CAP, EMIT.
- IDLE:
  - Goes to REQ when enable=1 and fifo_rdempty=0.
  - Otherwise stays in IDLE.
- REQ:
  - fifo_rdreq=1 for exactly this cycle.
  - Unconditionally goes to CAP.
  - fifo_rdreq is never asserted in any other state.
- CAP:
  - Captures fifo_q and sign-extends the code to SAMPLE_W+DECIM_LOG2 bits.
  - Adds the code to the accumulator.
  - OR-s the full-scale detect into the clip-accumulator.
  - Increments the sample counter.
  - If the counter reaches 2^DECIM_LOG2: load the output register, clear the accumulator/counter/clip-accumulator, and go to EMIT.
  - Otherwise go back to IDLE.
- Output register load:
  - avg_data = accumulator_sum >>> DECIM_LOG2 (arithmetic shift, floor toward -inf; no rounding).
  - avg_clip = the clip-accumulator value including the current sample.
  - avg_valid=1 from the next cycle.
- EMIT:
  - avg_valid held at 1; avg_data and avg_clip are stable until accepted.
  - On avg_ready=1: avg_valid drops next cycle, block_count increments, go to IDLE.
  - No FIFO reads occur while in EMIT; backpressure is absorbed by the FIFO.
- Throughput: at most 1 sample per 3 cycles (IDLE -> REQ -> CAP).
- Latency: the last code of a block is captured in CAP, and avg_valid rises on the following edge.
- Accumulator width is SAMPLE_W+DECIM_LOG2 bits and cannot overflow for any input.
- DECIM_LOG2=0: each sample is passed through unchanged, one avg per sample.
- enable deasserted mid-block:
  - The partial accumulation is retained.
  - The outstanding REQ -> CAP pair completes.
  - Reads resume when enable returns.
- fifo_rdempty rising in the REQ cycle cannot occur: REQ is entered only on non-empty, and a single read is outstanding.
- Low 8 bits of fifo_q (status/CRC padding) are ignored.
- Reset mid-block or in EMIT: the pending average is discarded and block_count returns to 0.

Test Plan:
- Feed 8 words 0x00000100 (code +1), avg_ready=1 -> one avg_data=0x000001, avg_clip=0, block_count=1; 8 fifo_rdreq pulses, each separated by >=2 cycles.
- Feed codes +3,+3,+3,+3,-4,-4,-4,-4 (words 0x00000300, 0xFFFFFC00) -> sum -4, avg_data=0xFFFFFF (-1, floor), avg_clip=0.
- Feed 7x code 0 then 1x 0x7FFFFF00 -> avg_data=0x0FFFFF, avg_clip=1; the next block of zeros -> avg_clip=0 (clip does not stick across blocks).
- Hold avg_ready=0 for 50 cycles with 16 words queued -> avg_valid and avg_data stable, zero fifo_rdreq during EMIT; after release, the second avg follows and block_count=2.
- Drop enable after 4 samples for 20 cycles, then restore -> no reads while low; the average covers exactly 8 samples.
- Assert reset in EMIT and in CAP -> all outputs 0 immediately (asynchronous); the next 8 samples produce a fresh average, block_count=1.
